// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload predecode channel.
package acc_pkg;

    // Request payload: the raw instruction word offered by the core.
    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    // Predecode answer returned to the core.
    typedef struct packed {
        logic       p_accept;
        logic [1:0] p_writeback;
        logic [2:0] p_use_rs;
    } acc_prd_rsp_t;

    // One instruction-table entry: pattern, mask and the canned answer.
    typedef struct packed {
        logic [31:0]  instr_data;
        logic [31:0]  instr_mask;
        acc_prd_rsp_t prd_rsp;
    } acc_offl_instr_t;

    // Response-stage state: nothing held, or a response waiting for the core.
    typedef enum logic {
        PRD_IDLE,
        PRD_RSP
    } acc_prd_state_e;

endpackage

// File: rtl/acc_predecoder_if.sv
// Predecoder request/response channel bundle (requester = master).
interface acc_predecoder_if;
    logic                 flush;
    acc_pkg::acc_prd_req_t req;
    logic                 q_valid;
    logic                 q_ready;
    acc_pkg::acc_prd_rsp_t rsp;
    logic                 p_valid;
    logic                 p_ready;

    modport master (
        output flush, req, q_valid, p_ready,
        input  q_ready, rsp, p_valid
    );

    modport slave (
        input  flush, req, q_valid, p_ready,
        output q_ready, rsp, p_valid
    );
endinterface

// File: rtl/acc_predecoder_match.sv
// Combinational table lookup: lowest-index matching entry supplies the answer.
module acc_predecoder_match
    import acc_pkg::*;
#(
    parameter int              NumInstr  = 1,
    parameter acc_offl_instr_t [NumInstr-1:0] OfflInstr = '0
) (
    input  logic [31:0]  instr,
    output logic         hit,
    output acc_prd_rsp_t rsp
);

    // Scan from the top down so the lowest matching index is written last and wins.
    always_comb begin
        // NOTE: defaults first so every path assigns hit/rsp and no latch is inferred.
        hit = 1'b0;
        rsp = '0;
        for (int i = NumInstr - 1; i >= 0; i--) begin
            if ((instr & OfflInstr[i].instr_mask) ==
                (OfflInstr[i].instr_data & OfflInstr[i].instr_mask)) begin
                hit = 1'b1;
                rsp = OfflInstr[i].prd_rsp;
            end
        end
    end

endmodule

// File: rtl/acc_predecoder.sv
// Accelerator predecoder: one registered response stage behind a table lookup.
module acc_predecoder
    import acc_pkg::*;
#(
    parameter int              NumInstr  = 1,
    parameter acc_offl_instr_t [NumInstr-1:0] OfflInstr = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  acc_prd_req_t prd_req_i,
    input  logic         prd_q_valid_i,
    output logic         prd_q_ready_o,
    output acc_prd_rsp_t prd_rsp_o,
    output logic         prd_p_valid_o,
    input  logic         prd_p_ready_i
);

    acc_prd_state_e state_q, state_d;
    acc_prd_rsp_t   rsp_q;
    acc_prd_rsp_t   match_rsp;
    logic           match_hit;
    logic           req_hs;
    logic           load;

    acc_predecoder_match #(
        .NumInstr  (NumInstr),
        .OfflInstr (OfflInstr)
    ) i_match (
        .instr (prd_req_i.q_instr_data),
        .hit   (match_hit),
        .rsp   (match_rsp)
    );

    // A new request fits when nothing is held or the held response leaves this cycle.
    assign prd_q_ready_o = !flush_i && (state_q == PRD_IDLE || prd_p_ready_i);
    assign req_hs        = prd_q_valid_i && prd_q_ready_o;
    assign prd_p_valid_o = (state_q == PRD_RSP);
    assign prd_rsp_o     = rsp_q;

    // Next-state and register-load decision; flush overrides everything.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (flush_i) begin
            state_d = PRD_IDLE;
        end else begin
            unique case (state_q)
                PRD_IDLE: begin
                    if (req_hs) begin
                        load    = 1'b1;
                        state_d = PRD_RSP;
                    end
                end
                PRD_RSP: begin
                    if (prd_p_ready_i) begin
                        if (req_hs) begin
                            load = 1'b1;
                        end else begin
                            state_d = PRD_IDLE;
                        end
                    end
                end
                default: state_d = PRD_IDLE;
            endcase
        end
    end

    // State register and response register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the response register is reset as well because it drives prd_rsp_o directly.
        if (!rst_ni) begin
            state_q <= PRD_IDLE;
            rsp_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the values from before the edge.
            state_q <= state_d;
            if (load) begin
                rsp_q <= match_hit ? match_rsp : '0;
            end
        end
    end

endmodule

// File: tb/tb_acc_predecoder.sv
// Self-checking bench for acc_predecoder: directed tables, corner sequences, random traffic.
module tb_acc_predecoder;
    import acc_pkg::*;

    // Main table: two overlapping entries (2 beats 3 on funct3=5) and a miss opcode 0x33.
    localparam acc_offl_instr_t EA0 = '{instr_data: 32'h0000_000B, instr_mask: 32'h0000_007F,
        prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b01, p_use_rs: 3'b011}};
    localparam acc_offl_instr_t EA1 = '{instr_data: 32'h0000_002B, instr_mask: 32'h0000_007F,
        prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b10, p_use_rs: 3'b101}};
    localparam acc_offl_instr_t EA2 = '{instr_data: 32'h0000_5057, instr_mask: 32'h0000_707F,
        prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b11, p_use_rs: 3'b110}};
    localparam acc_offl_instr_t EA3 = '{instr_data: 32'h0000_0057, instr_mask: 32'h0000_007F,
        prd_rsp: '{p_accept: 1'b0, p_writeback: 2'b00, p_use_rs: 3'b100}};
    localparam acc_offl_instr_t [3:0] TABLE_A = {EA3, EA2, EA1, EA0};

    // Second table: entry 1 is a catch-all (mask 0) shadowed by entry 0.
    localparam acc_offl_instr_t EB0 = '{instr_data: 32'h0000_000B, instr_mask: 32'h0000_007F,
        prd_rsp: '{p_accept: 1'b0, p_writeback: 2'b00, p_use_rs: 3'b001}};
    localparam acc_offl_instr_t EB1 = '{instr_data: 32'h0000_0000, instr_mask: 32'h0000_0000,
        prd_rsp: '{p_accept: 1'b1, p_writeback: 2'b10, p_use_rs: 3'b111}};
    localparam acc_offl_instr_t [1:0] TABLE_B = {EB1, EB0};

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    acc_predecoder_if if_a ();
    acc_predecoder_if if_b ();

    acc_predecoder #(.NumInstr(4), .OfflInstr(TABLE_A)) dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (if_a.flush),
        .prd_req_i     (if_a.req),
        .prd_q_valid_i (if_a.q_valid),
        .prd_q_ready_o (if_a.q_ready),
        .prd_rsp_o     (if_a.rsp),
        .prd_p_valid_o (if_a.p_valid),
        .prd_p_ready_i (if_a.p_ready)
    );

    acc_predecoder #(.NumInstr(2), .OfflInstr(TABLE_B)) dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (if_b.flush),
        .prd_req_i     (if_b.req),
        .prd_q_valid_i (if_b.q_valid),
        .prd_q_ready_o (if_b.q_ready),
        .prd_rsp_o     (if_b.rsp),
        .prd_p_valid_o (if_b.p_valid),
        .prd_p_ready_i (if_b.p_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  exp_rsp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference: first table entry (lowest index) whose masked bits agree wins.
    function automatic acc_prd_rsp_t ref_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (((w ^ TABLE_A[i].instr_data) & TABLE_A[i].instr_mask) == 32'h0)
                return TABLE_A[i].prd_rsp;
        end
        return '0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'h0B;
            1: w[6:0] = 7'h2B;
            2: begin w[6:0] = 7'h57; w[14:12] = 3'd5; end
            3: w[6:0] = 7'h57;
            4: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        acc_prd_rsp_t exp_q[$];
        acc_prd_rsp_t first_rsp;
        logic         model_ready;

        vecs[0] = '{32'h1234_500B, 6'h2B};
        vecs[1] = '{32'h0000_002B, 6'h35};
        vecs[2] = '{32'h0000_5057, 6'h3E};
        vecs[3] = '{32'h0000_1057, 6'h04};
        vecs[4] = '{32'h0000_0033, 6'h00};
        vecs[5] = '{32'hFFFF_FF8B, 6'h2B};
        vecs[6] = '{32'hABCD_D057, 6'h3E};
        vecs[7] = '{32'h0000_0013, 6'h00};

        rst_n = 1'b1;
        if_a.flush = 1'b0; if_a.q_valid = 1'b0; if_a.p_ready = 1'b1; if_a.req = '0;
        if_b.flush = 1'b0; if_b.q_valid = 1'b0; if_b.p_ready = 1'b1; if_b.req = '0;
        #1 rst_n = 1'b0;

        // Reset state.
        tick(); settle();
        check("reset_p_valid", 32'(if_a.p_valid), 32'd0);
        check("reset_rsp",     32'(if_a.rsp),     32'd0);
        check("reset_q_ready", 32'(if_a.q_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick(); settle();
        check("idle_p_valid", 32'(if_a.p_valid), 32'd0);

        // Single hit then a miss.
        if_a.req = 32'h1234_500B; if_a.q_valid = 1'b1;
        settle();
        check("hit_q_ready", 32'(if_a.q_ready), 32'd1);
        tick();
        if_a.req = 32'h0000_0033;
        settle();
        check("hit_p_valid", 32'(if_a.p_valid), 32'd1);
        check("hit_rsp",     32'(if_a.rsp),     32'h2B);
        tick();
        if_a.q_valid = 1'b0;
        settle();
        check("miss_p_valid", 32'(if_a.p_valid), 32'd1);
        check("miss_rsp",     32'(if_a.rsp),     32'h00);
        tick(); settle();
        check("drain_p_valid", 32'(if_a.p_valid), 32'd0);

        // Overlapping entries: lowest index wins, catch-all otherwise.
        if_b.req = 32'h0000_000B; if_b.q_valid = 1'b1;
        tick();
        if_b.req = 32'h0000_0013;
        settle();
        check("overlap_e0_rsp", 32'(if_b.rsp), 32'h01);
        tick();
        if_b.q_valid = 1'b0;
        settle();
        check("overlap_e1_rsp", 32'(if_b.rsp), 32'h37);
        tick();

        // Backpressure: response held 5 cycles, queued request waits, then no bubble.
        if_a.p_ready = 1'b0; if_a.req = 32'h0000_002B; if_a.q_valid = 1'b1;
        tick();
        if_a.req = 32'h0000_5057;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_p_valid", 32'(if_a.p_valid), 32'd1);
            check("bp_rsp",     32'(if_a.rsp),     32'h35);
            check("bp_q_ready", 32'(if_a.q_ready), 32'd0);
            tick();
        end
        if_a.p_ready = 1'b1;
        settle();
        check("bp_release_q_ready", 32'(if_a.q_ready), 32'd1);
        check("bp_release_rsp",     32'(if_a.rsp),     32'h35);
        tick();
        if_a.q_valid = 1'b0;
        settle();
        check("bp_second_p_valid", 32'(if_a.p_valid), 32'd1);
        check("bp_second_rsp",     32'(if_a.rsp),     32'h3E);
        tick(); settle();
        check("bp_drain_p_valid", 32'(if_a.p_valid), 32'd0);

        // Streaming: one request per cycle, responses back to back and in order.
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                if_a.req = vecs[k].instr; if_a.q_valid = 1'b1;
            end else begin
                if_a.q_valid = 1'b0;
            end
            settle();
            check("stream_q_ready", 32'(if_a.q_ready), 32'd1);
            if (k > 0) begin
                check("stream_p_valid", 32'(if_a.p_valid), 32'd1);
                check("stream_rsp",     32'(if_a.rsp),     32'(vecs[k-1].exp_rsp));
            end
            tick();
        end
        settle();
        check("stream_end_p_valid", 32'(if_a.p_valid), 32'd0);

        // Flush while a response is held under backpressure, with a request pending.
        if_a.p_ready = 1'b0; if_a.req = 32'h0000_000B; if_a.q_valid = 1'b1;
        tick();
        if_a.flush = 1'b1; if_a.req = 32'h0000_002B;
        settle();
        check("flush_q_ready", 32'(if_a.q_ready), 32'd0);
        tick();
        if_a.flush = 1'b0; if_a.q_valid = 1'b0; if_a.p_ready = 1'b1;
        settle();
        check("flush_p_valid", 32'(if_a.p_valid), 32'd0);
        tick(); settle();
        check("flush_no_accept", 32'(if_a.p_valid), 32'd0);

        // Asynchronous reset while a response is held.
        if_a.p_ready = 1'b0; if_a.req = 32'h0000_000B; if_a.q_valid = 1'b1;
        tick();
        if_a.q_valid = 1'b0;
        settle();
        check("pre_rst_p_valid", 32'(if_a.p_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_p_valid", 32'(if_a.p_valid), 32'd0);
        check("async_rst_rsp",     32'(if_a.rsp),     32'd0);
        tick();
        rst_n = 1'b1;
        if_a.p_ready = 1'b1;
        tick();

        // Random traffic against a queue model of outstanding responses.
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            if_a.flush   = ($urandom_range(0, 15) == 0);
            if_a.q_valid = $urandom_range(0, 1) == 1;
            if_a.p_ready = $urandom_range(0, 3) != 0;
            if_a.req     = rand_instr();
            settle();
            model_ready = !if_a.flush && (exp_q.size() == 0 || if_a.p_ready);
            check("rand_p_valid", 32'(if_a.p_valid), 32'(exp_q.size() != 0));
            check("rand_q_ready", 32'(if_a.q_ready), 32'(model_ready));
            if (exp_q.size() != 0) begin
                first_rsp = exp_q[0];
                check("rand_rsp", 32'(if_a.rsp), 32'(first_rsp));
                if (if_a.p_ready) void'(exp_q.pop_front());
            end
            if (if_a.flush) exp_q.delete();
            else if (if_a.q_valid && model_ready) exp_q.push_back(ref_a(if_a.req.q_instr_data));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
